// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit side of the CPU's memory-mapped UART. The CPU offers bytes on a
// valid/ready handshake. The bytes wait in a small FIFO so that back-to-back
// stores do not stall. A four-state FSM pulls each byte out of the FIFO and
// sends it as an 8N1 frame: one start bit (0), eight data bits LSB first, and
// one stop bit (1). Every bit lasts BitTime = ClockFreq / BaudRate cycles.
//
// Parameters
//   ClockFreq    system clock frequency in Hz
//   BaudRate     line rate in bits/s (ClockFreq / BaudRate must be >= 2)
//   FifoDepth    number of buffered bytes (power of 2, >= 2)
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   DataIn       in   byte to transmit
//   DataInValid  in   DataIn is offered this cycle
//   DataInReady  out  FIFO can accept a byte this cycle (not full)
//   SOut         out  serial line, idles high, driven from a register
//   Busy         out  a frame is in progress or the FIFO holds bytes
//   Level        out  bytes waiting in the FIFO (the byte on the line is
//                     not counted)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int FifoDepth = 4
) (
    input  logic                           Clock,
    input  logic                           Reset_n,
    input  logic [7:0]                     DataIn,
    input  logic                           DataInValid,
    output logic                           DataInReady,
    output logic                           SOut,
    output logic                           Busy,
    output logic [$clog2(FifoDepth+1)-1:0] Level
);

    localparam int BitTime = ClockFreq / BaudRate;
    localparam int CntW    = (BitTime > 1) ? $clog2(BitTime) : 1;
    localparam int PtrW    = $clog2(FifoDepth);
    localparam int LvlW    = $clog2(FifoDepth + 1);

    localparam logic [CntW-1:0] BaudLast  = CntW'(BitTime - 1);
    localparam logic [LvlW-1:0] FullCount = LvlW'(FifoDepth);
    localparam logic [LvlW-1:0] OneCount  = LvlW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [LvlW-1:0] count_reg;

    // -------------------------------------------------------------------------
    // Serializer state
    // -------------------------------------------------------------------------
    state_t          state_reg;
    logic [CntW-1:0] baud_cnt_reg;
    logic [2:0]      bit_idx_reg;
    logic [7:0]      shift_reg;
    logic            sout_reg;

    logic            fifo_empty;
    logic            baud_last;
    logic            push;
    logic            pop;

    assign fifo_empty  = (count_reg == '0);
    // Ready depends only on the occupancy, never on DataInValid. This keeps
    // the CPU-side handshake free of combinational loops.
    assign DataInReady = (count_reg != FullCount);
    assign push        = DataInValid & DataInReady;
    assign baud_last   = (baud_cnt_reg == BaudLast);

    // A byte leaves the FIFO at the moment a frame starts. A frame starts
    // either from IDLE, or on the last STOP cycle, so consecutive frames
    // follow each other without an idle gap.
    assign pop = !fifo_empty &&
                 ((state_reg == IDLE) || ((state_reg == STOP) && baud_last));

    // The storage array has no reset. Its contents are only ever read
    // behind the count, so any stale data is harmless.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= DataIn;
        end
    end

    // The pointers are log2(depth) wide and wrap on their own. The count
    // is kept separately so that full and empty are easy to tell apart.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + OneCount;
                2'b01:   count_reg <= count_reg - OneCount;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM
    // sout_reg is loaded with the value of the bit that the next state drives.
    // As a result, SOut changes on the same edge as the state.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            sout_reg     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_cnt_reg <= '0;
                    bit_idx_reg  <= '0;
                    sout_reg     <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        sout_reg  <= 1'b0;
                        state_reg <= START;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        sout_reg     <= shift_reg[0];
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CntW'(1);
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        bit_idx_reg  <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            sout_reg  <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            // Bit 1 of the current shift value is the next
                            // data bit, once the right shift has happened.
                            sout_reg <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CntW'(1);
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            sout_reg  <= 1'b0;
                            state_reg <= START;
                        end else begin
                            sout_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CntW'(1);
                    end
                end

                default: begin
                    baud_cnt_reg <= '0;
                    bit_idx_reg  <= '0;
                    sout_reg     <= 1'b1;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign SOut  = sout_reg;
    assign Level = count_reg;
    assign Busy  = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Checks uart_tx_fifo with BitTime = 10 and FifoDepth = 4. A behavioural
// model holds a queue of pending bytes and the elapsed time of the current
// frame. The expected line level is computed from the frame position:
// start bit, then data bits LSB first, then the stop bit. On every falling
// edge the bench compares SOut, Level, Busy and DataInReady with the model.
// Directed scenarios add point checks on top of that.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int BIT_T = 10;
    localparam int FRAME = 10 * BIT_T;
    localparam int DEPTH = 4;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic       DataInValid = 1'b0;
    logic       DataInReady;
    logic       SOut;
    logic       Busy;
    logic [2:0] Level;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .ClockFreq (1000),
        .BaudRate  (100),
        .FifoDepth (DEPTH)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .DataIn      (DataIn),
        .DataInValid (DataInValid),
        .DataInReady (DataInReady),
        .SOut        (SOut),
        .Busy        (Busy),
        .Level       (Level)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] q[$];
    bit         m_active = 1'b0;
    int         m_elapsed = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_push;
    logic [7:0] m_pd;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            q.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
        end else begin
            m_push = DataInValid && (q.size() < DEPTH);
            m_pd   = DataIn;
            // A frame ends after FRAME cycles. The next byte, taken from the
            // queue as it was before this edge, starts without an idle gap.
            if (m_active) begin
                if (m_elapsed == FRAME - 1) begin
                    $display("frame sent 0x%02h", m_cur);
                    if (q.size() > 0) begin
                        m_cur     = q.pop_front();
                        m_elapsed = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_elapsed++;
                end
            end else if (q.size() > 0) begin
                m_cur     = q.pop_front();
                m_active  = 1'b1;
                m_elapsed = 0;
            end
            if (m_push) begin
                q.push_back(m_pd);
                $display("push 0x%02h level %0d", m_pd, q.size());
            end
        end
    end

    function automatic logic exp_sout();
        int b;
        b = m_elapsed / BIT_T;
        if (!m_active) return 1'b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    bit check_en = 1'b0;
    always @(negedge Clock) begin
        if (check_en) begin
            check("sout", SOut, exp_sout());
            check("level", Level, q.size());
            check("busy", Busy, m_active || (q.size() != 0));
            check("ready", DataInReady, q.size() != DEPTH);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge Clock);
        DataInValid = v;
        DataIn      = d;
    endtask

    task automatic idle(input int n);
        @(negedge Clock);
        DataInValid = 1'b0;
        repeat (n - 1) @(negedge Clock);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        @(negedge Clock);
        DataInValid = 1'b0;
        while ((m_active || q.size() != 0) && c < budget) begin
            @(negedge Clock);
            c++;
        end
        check("drain_in_time", c < budget, 1);
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [7:0] v;

        // Reset state
        repeat (3) @(negedge Clock);
        check("rst_sout", SOut, 1);
        check("rst_level", Level, 0);
        check("rst_busy", Busy, 0);
        check("rst_ready", DataInReady, 1);
        check_en = 1'b1;
        #2 Reset_n = 1'b1;
        idle(3);

        // 1: single 0xA5 while idle
        drive(1'b1, 8'hA5);
        @(negedge Clock);
        DataInValid = 1'b0;
        @(negedge Clock);
        check("s1_start_low", SOut, 0);
        c = 0;
        while (Busy && c < 200) begin
            @(negedge Clock);
            c++;
        end
        check("s1_busy_len", c, FRAME);
        wait_drain(300);

        // 2: six back-to-back pushes; only five fit
        for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
        @(negedge Clock);
        DataInValid = 1'b0;
        check("s2_level_full", Level, 4);
        check("s2_ready_low", DataInReady, 0);
        wait_drain(800);

        // 3: push on the exact STOP-end pop edge with Level=2
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h33);
        @(negedge Clock);
        DataInValid = 1'b0;
        c = 0;
        while (!(m_active && m_elapsed == FRAME - 1 && q.size() == 2) && c < 300) begin
            @(negedge Clock);
            c++;
        end
        check("s3_reach_stop_end", c < 300, 1);
        DataInValid = 1'b1;
        DataIn      = 8'h77;
        @(negedge Clock);
        DataInValid = 1'b0;
        check("s3_level_same", Level, 2);
        wait_drain(600);

        // 4: reset during data bit 3 of 0x5A; writes ignored while in reset
        drive(1'b1, 8'h5A);
        @(negedge Clock);
        DataInValid = 1'b0;
        c = 0;
        while (!(m_active && m_elapsed == 4 * BIT_T + 5) && c < 200) begin
            @(negedge Clock);
            c++;
        end
        check("s4_reach_bit3", c < 200, 1);
        #2;
        Reset_n     = 1'b0;
        DataInValid = 1'b1;
        DataIn      = 8'hEE;
        #1;
        check("s4_rst_sout", SOut, 1);
        check("s4_rst_level", Level, 0);
        check("s4_rst_busy", Busy, 0);
        check("s4_rst_ready", DataInReady, 1);
        repeat (3) @(negedge Clock);
        DataInValid = 1'b0;
        #2 Reset_n = 1'b1;
        drive(1'b1, 8'h3C);
        wait_drain(300);

        // 5: all-zero and all-one bytes
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        wait_drain(400);

        // 6: hold valid with changing data while full
        for (int i = 0; i < 260; i++) begin
            v = 8'($urandom);
            drive(1'b1, v);
        end
        wait_drain(800);

        // 7: random traffic
        for (int i = 0; i < 1500; i++) begin
            v = 8'($urandom);
            drive(($urandom_range(0, 99) < 30), v);
        end
        wait_drain(1000);

        check("end_idle_sout", SOut, 1);
        check("end_idle_busy", Busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
